// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch PC generator and its queue.
package fetch_pkg;

  localparam int PC_W = 32;
  localparam int META_W = 4;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  // One fetched PC together with the prediction made for it.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              p_dir;
    logic [PC_W-1:0]   p_target;
    logic [META_W-1:0] meta;
  } fq_entry_t;

endpackage

// File: rtl/fetch_pcgen_if.sv
// Fetch-to-decode handshake: queue head payload plus decode's ready.
interface fetch_pcgen_if #(
  parameter int PC_W = fetch_pkg::PC_W,
  parameter int META_W = fetch_pkg::META_W
);

  logic              fetch_decode_valid;
  logic [PC_W-1:0]   fetch_decode_PC;
  logic              fetch_decode_p_dir;
  logic [PC_W-1:0]   fetch_decode_p_target;
  logic [META_W-1:0] fetch_decode_meta;
  logic              decode_fetch_ready;

  modport master (
    output fetch_decode_valid,
    output fetch_decode_PC,
    output fetch_decode_p_dir,
    output fetch_decode_p_target,
    output fetch_decode_meta,
    input  decode_fetch_ready
  );

  modport slave (
    input  fetch_decode_valid,
    input  fetch_decode_PC,
    input  fetch_decode_p_dir,
    input  fetch_decode_p_target,
    input  fetch_decode_meta,
    output decode_fetch_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order circular FIFO of fetched entries. Wrap-around pointers plus a
// separate occupancy count so that full (count = DEPTH) and empty differ.
// Flush wins over push and pop in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fq_entry_t        push_data,
  input  logic             pop,
  output fq_entry_t        head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !flush;
  assign pop_ok  = pop && (cnt != '0) && !flush;

  // Entry storage; cleared on reset so the head payload reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head is read straight out of registered storage: no bypass of a push.
  assign head       = mem[rd_ptr];
  assign head_valid = (cnt != '0);
  assign count      = cnt;

endmodule

// File: rtl/fetch_pcgen.sv
// Fetch-stage PC generator: issues pc_f0 to the branch predictor, captures
// the response one cycle later (F1), steers the next PC and enqueues each
// fetched PC with its prediction for decode.
module fetch_pcgen #(
  parameter int PC_W = fetch_pkg::PC_W,
  parameter int META_W = fetch_pkg::META_W,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   fetch_bpredictor_PC,
  output logic              fetch_bpredictor_stall,
  input  logic              bpredictor_fetch_p_dir,
  input  logic [PC_W-1:0]   bpredictor_fetch_p_target,
  input  logic [META_W-1:0] bpredictor_fetch_meta,
  input  logic              fetch_redirect,
  input  logic [PC_W-1:0]   fetch_redirect_PC,
  fetch_pcgen_if.master     dec
);

  import fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  pc_f0;
  logic [PC_W-1:0]  pc_f1;
  logic             f1_valid;
  logic             stall;
  logic             taken;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] q_count;
  logic             head_valid;
  fq_entry_t        push_entry;
  fq_entry_t        head_entry;

  // Stall one short of full: the lookup already in flight still needs a slot.
  // A redirect always proceeds because it empties the queue.
  assign stall = (q_count >= CNT_W'(DEPTH - 1)) && !fetch_redirect;
  assign taken = f1_valid && bpredictor_fetch_p_dir;
  assign push  = f1_valid && !fetch_redirect;
  assign pop   = head_valid && dec.decode_fetch_ready;

  // Package the F1 response for the queue.
  always_comb begin
    push_entry          = '0;
    push_entry.pc       = pc_f1;
    push_entry.p_dir    = bpredictor_fetch_p_dir;
    push_entry.p_target = bpredictor_fetch_p_target;
    push_entry.meta     = bpredictor_fetch_meta;
  end

  // F0 -> F1 boundary: issue register, in-flight lookup and next-PC select.
  // Redirect beats a predicted-taken response, which beats sequential fetch.
  // Clearing f1_valid on taken/redirect kills the lookup issued this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f0    <= RESET_PC;
      pc_f1    <= '0;
      f1_valid <= 1'b0;
    end else begin
      if (!stall) begin
        pc_f1 <= pc_f0;
      end
      if (fetch_redirect) begin
        pc_f0    <= fetch_redirect_PC;
        f1_valid <= 1'b0;
      end else if (taken) begin
        pc_f0    <= bpredictor_fetch_p_target;
        f1_valid <= 1'b0;
      end else if (!stall) begin
        pc_f0    <= pc_f0 + PC_W'(4);
        f1_valid <= 1'b1;
      end else begin
        f1_valid <= 1'b0;
      end
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (fetch_redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .head_valid(head_valid),
    .count     (q_count)
  );

  assign fetch_bpredictor_PC    = pc_f0;
  assign fetch_bpredictor_stall = stall;

  assign dec.fetch_decode_valid    = head_valid;
  assign dec.fetch_decode_PC       = head_entry.pc;
  assign dec.fetch_decode_p_dir    = head_entry.p_dir;
  assign dec.fetch_decode_p_target = head_entry.p_target;
  assign dec.fetch_decode_meta     = head_entry.meta;

endmodule

// File: tb/tb_fetch_pcgen.sv
// Bench for fetch_pcgen: a queue-based behavioural model checked every cycle,
// plus directed scenarios with literal expectations on issued/decoded PCs.
module tb_fetch_pcgen;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] bp_pc;
  logic        bp_stall;
  logic        bp_dir = 1'b0;
  logic [31:0] bp_target = '0;
  logic [3:0]  bp_meta = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  fetch_pcgen_if #(.PC_W(32), .META_W(4)) dif ();

  fetch_pcgen #(
    .PC_W(32), .META_W(4), .DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk                      (clk),
    .reset                    (rst_n),
    .fetch_bpredictor_PC      (bp_pc),
    .fetch_bpredictor_stall   (bp_stall),
    .bpredictor_fetch_p_dir   (bp_dir),
    .bpredictor_fetch_p_target(bp_target),
    .bpredictor_fetch_meta    (bp_meta),
    .fetch_redirect           (redirect),
    .fetch_redirect_PC        (redirect_pc),
    .dec                      (dif)
  );

  typedef struct {
    logic [31:0] pc;
    logic        dir;
    logic [31:0] tgt;
    logic [3:0]  meta;
  } ent_t;

  // Model state: what the PC must be, the lookup in flight, the queue.
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_busy;
  logic [31:0] m_fpc;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] issued[$];
  logic [31:0] decoded[$];
  int          cyc;
  int          first_valid;
  int          first_stall;

  bit          taken_en = 1'b0;
  logic [31:0] taken_pc = '0;
  logic [31:0] taken_tgt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int count_of(input logic [31:0] q[$], input logic [31:0] v);
    int n = 0;
    foreach (q[i]) if (q[i] == v) n++;
    return n;
  endfunction

  function automatic bit m_stall();
    return (mq.size() >= DEPTH - 1) && !redirect;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = RST_PC;
    m_busy = 1'b0;
    m_fpc  = '0;
  endtask

  // Next state from the current inputs, applied as of the coming edge.
  task automatic model_advance();
    bit stl;
    stl = m_stall();
    if (redirect) begin
      mq.delete();
      m_busy = 1'b0;
      m_pc   = redirect_pc;
    end else begin
      if (mq.size() != 0 && dif.decode_fetch_ready) void'(mq.pop_front());
      if (m_busy) mq.push_back('{pc: m_fpc, dir: bp_dir, tgt: bp_target, meta: bp_meta});
      if (m_busy && bp_dir) begin
        m_pc   = bp_target;
        m_busy = 1'b0;
      end else if (!stl) begin
        m_fpc  = m_pc;
        m_busy = 1'b1;
        m_pc   = m_pc + 32'd4;
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic compare_cycle();
    chk("issue_pc", bp_pc, m_pc);
    chk("stall", bp_stall, m_stall());
    chk("dec_valid", dif.fetch_decode_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("dec_pc", dif.fetch_decode_PC, mq[0].pc);
      chk("dec_dir", dif.fetch_decode_p_dir, mq[0].dir);
      chk("dec_target", dif.fetch_decode_p_target, mq[0].tgt);
      chk("dec_meta", dif.fetch_decode_meta, mq[0].meta);
    end
    if (!bp_stall) issued.push_back(bp_pc);
    if (dif.fetch_decode_valid && dif.decode_fetch_ready) decoded.push_back(dif.fetch_decode_PC);
    if (dif.fetch_decode_valid && first_valid < 0) first_valid = cyc;
    if (bp_stall && first_stall < 0) first_stall = cyc;
    cyc++;
  endtask

  // One clock: compare at the falling edge, advance model, then play the
  // predictor's response to whatever was looked up this cycle.
  task automatic step();
    logic [31:0] ipc;
    bit          iss;
    @(negedge clk);
    compare_cycle();
    ipc = bp_pc;
    iss = !bp_stall;
    model_advance();
    @(posedge clk);
    #1;
    bp_dir    = iss && taken_en && (ipc == taken_pc);
    bp_target = bp_dir ? taken_tgt : ipc + 32'h100;
    bp_meta   = ipc[5:2] ^ 4'hA;
  endtask

  task automatic drop_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    bp_dir = 1'b0;
    bp_target = '0;
    bp_meta = '0;
    taken_en = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", bp_pc, RST_PC);
    chk("rst_stall", bp_stall, 1'b0);
    chk("rst_valid", dif.fetch_decode_valid, 1'b0);
    chk("rst_dec_pc", dif.fetch_decode_PC, 32'h0);
    chk("rst_dec_target", dif.fetch_decode_p_target, 32'h0);
    chk("rst_dec_meta", dif.fetch_decode_meta, 4'h0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issued.delete();
    decoded.delete();
    cyc = 0;
    first_valid = -1;
    first_stall = -1;
  endtask

  task automatic do_reset(input logic ready);
    dif.decode_fetch_ready = ready;
    drop_reset();
    release_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.decode_fetch_ready = 1'b1;
    model_reset();
    #2;

    // Reset and sequential fetch
    do_reset(1'b1);
    repeat (6) step();
    chk("seq_issue0", q_at(issued, 0), 32'h0);
    chk("seq_issue1", q_at(issued, 1), 32'h4);
    chk("seq_issue2", q_at(issued, 2), 32'h8);
    chk("seq_issue3", q_at(issued, 3), 32'hC);
    chk("seq_first_head_cycle", first_valid, 2);
    chk("seq_dec0", q_at(decoded, 0), 32'h0);

    // Predicted taken at PC 8 -> 0x40
    do_reset(1'b1);
    taken_en = 1'b1; taken_pc = 32'h8; taken_tgt = 32'h40;
    repeat (10) step();
    chk("tk_issue3", q_at(issued, 3), 32'hC);
    chk("tk_issue4", q_at(issued, 4), 32'h40);
    chk("tk_issue5", q_at(issued, 5), 32'h44);
    chk("tk_dec2", q_at(decoded, 2), 32'h8);
    chk("tk_dec3", q_at(decoded, 3), 32'h40);
    chk("tk_no_12", count_of(decoded, 32'hC), 0);

    // Backpressure from reset
    do_reset(1'b0);
    repeat (6) step();
    chk("bp_first_stall", first_stall, 4);
    chk("bp_stall", bp_stall, 1'b1);
    chk("bp_hold_pc", bp_pc, 32'h10);
    chk("bp_head", dif.fetch_decode_PC, 32'h0);
    chk("bp_issued_n", issued.size(), 4);
    dif.decode_fetch_ready = 1'b1;
    repeat (12) step();
    chk("bp_dec0", q_at(decoded, 0), 32'h0);
    chk("bp_dec1", q_at(decoded, 1), 32'h4);
    chk("bp_dec2", q_at(decoded, 2), 32'h8);
    chk("bp_dec3", q_at(decoded, 3), 32'hC);
    chk("bp_dec4", q_at(decoded, 4), 32'h10);
    chk("bp_dec5", q_at(decoded, 5), 32'h14);

    // Redirect in the same cycle as a taken response
    do_reset(1'b0);
    taken_en = 1'b1; taken_pc = 32'hC; taken_tgt = 32'h40;
    repeat (4) step();
    chk("rd_pre_valid", dif.fetch_decode_valid, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("rd_pc", bp_pc, 32'h100);
    chk("rd_valid_t1", dif.fetch_decode_valid, 1'b0);
    step();
    chk("rd_valid_t2", dif.fetch_decode_valid, 1'b0);
    step();
    chk("rd_valid_t3", dif.fetch_decode_valid, 1'b1);
    chk("rd_head_t3", dif.fetch_decode_PC, 32'h100);
    dif.decode_fetch_ready = 1'b1;
    repeat (6) step();
    chk("rd_no_40_issued", count_of(issued, 32'h40), 0);
    chk("rd_no_40_decoded", count_of(decoded, 32'h40), 0);
    chk("rd_dec0", q_at(decoded, 0), 32'h100);
    chk("rd_dec1", q_at(decoded, 1), 32'h104);

    // PC wrap-around
    do_reset(1'b1);
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_pc0", bp_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc1", bp_pc, 32'h0);
    step();
    chk("wrap_head0", dif.fetch_decode_PC, 32'hFFFF_FFFC);
    step();
    chk("wrap_head1", dif.fetch_decode_PC, 32'h0);

    // Asynchronous reset between edges with the queue full
    do_reset(1'b0);
    repeat (6) step();
    chk("ar_pre_valid", dif.fetch_decode_valid, 1'b1);
    #2;
    drop_reset();
    release_reset();
    dif.decode_fetch_ready = 1'b1;
    repeat (5) step();
    chk("ar_issue0", q_at(issued, 0), RST_PC);
    chk("ar_issue1", q_at(issued, 1), RST_PC + 32'd4);
    chk("ar_dec0", q_at(decoded, 0), RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
